// File: rtl/yarp_pkg.sv
// Shared types and constants for the yarp front end.
// Fetch entries pair an instruction word with the PC it was read from.
package yarp_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] next_pc(
    input logic [XLEN-1:0] pc
  );
    return pc + XLEN'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/yarp_fetch_unit_if.sv
// Instruction-memory request/response bus between fetch and imem.
// Signal names are from the fetch unit's point of view.
interface yarp_fetch_unit_if;
  import yarp_pkg::*;

  logic            fetch_req_o;
  logic [XLEN-1:0] fetch_addr_o;
  logic            fetch_gnt_i;
  logic            fetch_rvalid_i;
  logic [XLEN-1:0] fetch_rdata_i;

  modport master (
    output fetch_req_o,
    output fetch_addr_o,
    input  fetch_gnt_i,
    input  fetch_rvalid_i,
    input  fetch_rdata_i
  );

  modport slave (
    input  fetch_req_o,
    input  fetch_addr_o,
    output fetch_gnt_i,
    output fetch_rvalid_i,
    output fetch_rdata_i
  );

endinterface

// File: rtl/yarp_fetch_fifo.sv
// Instruction buffer: registered FIFO of fetch entries, head read
// straight from storage, synchronous flush.
module yarp_fetch_fifo
  import yarp_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         push_i,
  input  fetch_entry_t                 din_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output fetch_entry_t                 head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_ptr_q];

  // The head slot may be rewritten while it is popped.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || pop_i);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/yarp_fetch_unit.sv
// Fetch stage: PC, credit-limited imem reads, redirect and drop logic.
// Misaligned-target halting is built when YARP_FETCH_MISALIGN_CHK_EN is defined.
module yarp_fetch_unit
  import yarp_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter int              BUF_DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  yarp_fetch_unit_if.master   mem_if,
  input  logic                redirect_i,
  input  logic [XLEN-1:0]     redirect_pc_i,
  output logic                instr_valid_o,
  input  logic                instr_ready_i,
  output logic [XLEN-1:0]     instr_o,
  output logic [XLEN-1:0]     instr_pc_o,
  output logic                instr_misalign_o
);

  localparam int CW = $clog2(BUF_DEPTH+1);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [XLEN-1:0] tgt_pc;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   buf_cnt;
  logic [CW:0]     inflight;
  logic            run_q;
  logic            halt_q, halt_d;
  logic            mis_q, mis_d;
  logic            req, issue, rvalid, keep, pop;
  logic            full, empty;
  fetch_entry_t    din, head;

`ifdef YARP_FETCH_MISALIGN_CHK_EN
  logic misal;
  assign misal  = |redirect_pc_i[1:0];
  assign tgt_pc = redirect_pc_i;
`else
  logic unused_pc_lsb;
  assign unused_pc_lsb = ^redirect_pc_i[1:0];
  assign tgt_pc = {redirect_pc_i[XLEN-1:2], 2'b00};
`endif

  assign rvalid = mem_if.fetch_rvalid_i;
  assign pop    = instr_valid_o && instr_ready_i;
  assign keep   = rvalid && drop_q == '0 && !redirect_i;

  // An entry leaving this cycle frees its slot, sustaining 1 instr/cycle.
  assign inflight = {1'b0, outst_q} + {1'b0, buf_cnt} - {{CW{1'b0}}, pop};
  assign req      = run_q && !redirect_i && !halt_q
                 && inflight < (CW+1)'(BUF_DEPTH);
  assign issue    = req && mem_if.fetch_gnt_i;

  assign mem_if.fetch_req_o  = req;
  assign mem_if.fetch_addr_o = pc_q;

  always_comb begin
    pc_d     = pc_q;
    rsp_pc_d = keep ? next_pc(rsp_pc_q) : rsp_pc_q;
    outst_d  = outst_q + CW'(issue) - CW'(rvalid);
    drop_d   = (rvalid && drop_q != '0) ? drop_q - 1'b1 : drop_q;
    halt_d   = halt_q;
    mis_d    = mis_q;
    unique case (1'b1)
      redirect_i: pc_d = tgt_pc;
      issue:      pc_d = next_pc(pc_q);
      default:    ;
    endcase
    if (redirect_i) begin
      rsp_pc_d = tgt_pc;
      // A same-cycle response retires one read, stale-marked or not.
      drop_d   = outst_q - CW'(rvalid);
`ifdef YARP_FETCH_MISALIGN_CHK_EN
      halt_d   = misal;
      mis_d    = misal;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      outst_q  <= '0;
      drop_q   <= '0;
      run_q    <= 1'b0;
      halt_q   <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      outst_q  <= outst_d;
      drop_q   <= drop_d;
      run_q    <= 1'b1;
      halt_q   <= halt_d;
      mis_q    <= mis_d;
    end
  end

  assign din = '{instr: mem_if.fetch_rdata_i, pc: rsp_pc_q};

  yarp_fetch_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (keep),
    .din_i   (din),
    .pop_i   (pop),
    .flush_i (redirect_i),
    .full_o  (full),
    .empty_o (empty),
    .count_o (buf_cnt),
    .head_o  (head)
  );

  assign instr_valid_o    = !empty;
  assign instr_o          = head.instr;
  assign instr_pc_o       = head.pc;
  assign instr_misalign_o = mis_q;

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!reset_n)
    !(keep && full && !pop)
  );

endmodule

// File: tb/tb_yarp_fetch_unit.sv
// Scoreboard bench for yarp_fetch_unit: directed redirects, stalls,
// PC wrap; build with +define+YARP_FETCH_MISALIGN_CHK_EN for the halt case.
module tb_yarp_fetch_unit;
  import yarp_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  always #5 clk = ~clk;

  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        ready = 1'b0;
  logic        gnt = 1'b1;
  int          lat = 1;
  logic        ivalid, mis;
  logic [31:0] instr, ipc;
  logic        ivalid2, mis2;
  logic [31:0] instr2, ipc2;

  yarp_fetch_unit_if bus ();
  yarp_fetch_unit_if bus2 ();

  yarp_fetch_unit u_dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .mem_if           (bus),
    .redirect_i       (redirect),
    .redirect_pc_i    (redirect_pc),
    .instr_valid_o    (ivalid),
    .instr_ready_i    (ready),
    .instr_o          (instr),
    .instr_pc_o       (ipc),
    .instr_misalign_o (mis)
  );

  yarp_fetch_unit #(
    .RESET_PC (32'hFFFF_FFF8)
  ) u_dut_wrap (
    .clk              (clk),
    .reset_n          (reset_n),
    .mem_if           (bus2),
    .redirect_i       (1'b0),
    .redirect_pc_i    (32'h0),
    .instr_valid_o    (ivalid2),
    .instr_ready_i    (1'b1),
    .instr_o          (instr2),
    .instr_pc_o       (ipc2),
    .instr_misalign_o (mis2)
  );

  assign bus.fetch_gnt_i  = gnt;
  assign bus2.fetch_gnt_i = 1'b1;

  // Memory: in-order, lat cycles after issue, data = ~address.
  typedef struct { logic [31:0] a; int due; } mreq_t;
  mreq_t mq[$];
  int    mcyc;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      mcyc = 0;
      bus.fetch_rvalid_i <= 1'b0;
      bus.fetch_rdata_i  <= '0;
    end else begin
      mcyc++;
      if (bus.fetch_req_o && bus.fetch_gnt_i)
        mq.push_back('{a: bus.fetch_addr_o, due: mcyc + lat - 1});
      bus.fetch_rvalid_i <= 1'b0;
      if (mq.size() > 0 && mq[0].due <= mcyc) begin
        bus.fetch_rvalid_i <= 1'b1;
        bus.fetch_rdata_i  <= ~mq[0].a;
        void'(mq.pop_front());
      end
    end
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus2.fetch_rvalid_i <= 1'b0;
      bus2.fetch_rdata_i  <= '0;
    end else begin
      bus2.fetch_rvalid_i <= bus2.fetch_req_o;
      bus2.fetch_rdata_i  <= ~bus2.fetch_addr_o;
    end
  end

  typedef struct { logic [31:0] pc; logic [31:0] ins; } exp_t;
  exp_t        exp_q[$];
  exp_t        e;
  logic [31:0] a2_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_pop = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic path(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back('{pc: base + 32'(4*i), ins: ~(base + 32'(4*i))});
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic redir(input logic [31:0] t);
    redirect    = 1'b1;
    redirect_pc = t;
    #1 chk("redir_req_low", {31'b0, bus.fetch_req_o}, 32'h0);
    @(posedge clk);
    #1;
    redirect = 1'b0;
    exp_q.delete();
  endtask

  // Decode-side monitor.
  always @(negedge clk) begin
    if (reset_n && ivalid && ready) begin
      n_pop++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_instr: got pc %h want none", ipc);
      end else begin
        e = exp_q.pop_front();
        chk("instr_pc", ipc, e.pc);
        chk("instr", instr, e.ins);
      end
    end
  end

  // Wrap-DUT issue monitor.
  always @(negedge clk) begin
    if (reset_n && bus2.fetch_req_o && bus2.fetch_gnt_i && a2_q.size() > 0)
      chk("wrap_addr", bus2.fetch_addr_o, a2_q.pop_front());
  end

  initial begin
    int          snap;
    logic [31:0] a0;
    a2_q = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    #1 reset_n = 1'b0;
    #2;
    chk("rst_req", {31'b0, bus.fetch_req_o}, 32'h0);
    chk("rst_valid", {31'b0, ivalid}, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", ipc, 32'h0);
    chk("rst_mis", {31'b0, mis}, 32'h0);
    path(32'h0, 200);
    #20 reset_n = 1'b1;
    step(1);

    // 1: streaming, one instruction per cycle
    ready = 1'b1;
    step(6);
    snap = n_pop;
    step(20);
    chk("t1_throughput", 32'(n_pop - snap), 32'd20);
    gnt = 1'b0;
    step(1);
    a0 = bus.fetch_addr_o;
    step(3);
    chk("t1_hold_req", {31'b0, bus.fetch_req_o}, 32'h1);
    chk("t1_hold_addr", bus.fetch_addr_o, a0);
    gnt = 1'b1;
    step(4);

    // 2: decode stall fills buffer, credit stops requests
    ready = 1'b0;
    step(10);
    chk("t2_valid", {31'b0, ivalid}, 32'h1);
    chk("t2_req", {31'b0, bus.fetch_req_o}, 32'h0);
    ready = 1'b1;
    step(10);

    // 3: redirect with reads outstanding under slow memory
    lat = 3;
    step(4);
    redir(32'h80);
    step(2);
    redir(32'h100);
    path(32'h100, 100);
    chk("t3_addr", bus.fetch_addr_o, 32'h100);
    snap = n_pop;
    step(15);
    chk("t3_progress", {31'b0, (n_pop - snap) >= 3}, 32'h1);

    // back-to-back redirects
    redirect    = 1'b1;
    redirect_pc = 32'h400;
    step(1);
    redirect_pc = 32'h500;
    step(1);
    redirect = 1'b0;
    exp_q.delete();
    path(32'h500, 100);
    snap = n_pop;
    step(15);
    chk("t7_progress", {31'b0, (n_pop - snap) >= 3}, 32'h1);

    // 4: redirect coincides with response and pop
    lat = 1;
    step(8);
    chk("t4_pre", {30'b0, ivalid, bus.fetch_rvalid_i}, 32'h3);
    redir(32'h300);
    path(32'h300, 100);
    snap = n_pop;
    step(10);
    chk("t4_progress", {31'b0, (n_pop - snap) >= 5}, 32'h1);

    // 6: misaligned redirect target
    redir(32'h102);
`ifdef YARP_FETCH_MISALIGN_CHK_EN
    chk("t6_mis_set", {31'b0, mis}, 32'h1);
    chk("t6_req_off", {31'b0, bus.fetch_req_o}, 32'h0);
    step(5);
    chk("t6_req_still_off", {31'b0, bus.fetch_req_o}, 32'h0);
    chk("t6_no_valid", {31'b0, ivalid}, 32'h0);
    chk("t6_mis_sticky", {31'b0, mis}, 32'h1);
    redir(32'h200);
    path(32'h200, 100);
    chk("t6_mis_clr", {31'b0, mis}, 32'h0);
`else
    path(32'h100, 100);
    chk("t6_mis_off", {31'b0, mis}, 32'h0);
`endif
    snap = n_pop;
    step(10);
    chk("t6_progress", {31'b0, (n_pop - snap) >= 5}, 32'h1);

    // 5: wrap-DUT issued its three checked addresses
    chk("t5_done", 32'(a2_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
